rx_cmd_decoder: RTL and testbench

Frame-level command decoder that sits directly downstream of the UART receiver.
- Consumes each received byte (P_DATA qualified by a one-cycle data_valid pulse) and assembles multi-byte command frames.
- Issues register-file write and read requests and ALU operation requests to the system core.
- Runs entirely in the receiver's clock domain.

---
 rtl/rx_cmd_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_rx_cmd_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder: frame-level command decoder placed after the UART receiver.
// It assembles command frames from received bytes and issues register
// write/read requests and ALU operation requests, one strobe per frame.
//
// Frames:
//   AA addr data   register write
//   BB addr        register read
//   CC A B fun     ALU operation with new operands
//   DD fun         ALU operation with held operands
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   P_DATA     received byte, qualified by data_valid
//   data_valid one-cycle strobe per received byte
//   WrEn       register write strobe (1 cycle)
//   RdEn       register read strobe (1 cycle)
//   Address    register address (held)
//   WrData     register write data (held)
//   ALU_A      ALU operand A (held)
//   ALU_B      ALU operand B (held)
//   ALU_FUN    ALU function code (held)
//   ALU_EN     ALU start strobe (1 cycle)
//   cmd_err    unknown command byte or aborted frame (1 cycle)
//   busy       high while a frame is partially received
//
// Optional feature macro: FRAME_TIMEOUT_EN
//   When defined, a partial frame left idle for TIMEOUT_CYCLES cycles is
//   abandoned with a cmd_err pulse. When undefined, a partial frame waits
//   indefinitely.

module rx_cmd_decoder #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  output logic                  cmd_err,
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_NOP = DATA_WIDTH'(8'hDD);

  // A zero timeout would abort every frame immediately.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("rx_cmd_decoder: TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN
  } state_t;

  state_t                state, state_nxt;
  logic                  wr_en_nxt, rd_en_nxt, alu_en_nxt, cmd_err_nxt, busy_nxt;
  logic [ADDR_WIDTH-1:0] address_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt, alu_a_nxt, alu_b_nxt;
  logic [FUN_WIDTH-1:0]  alu_fun_nxt;
  logic                  tmo_fire;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] idle_cnt;

  // Counts idle cycles inside a frame; any received byte restarts it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idle_cnt <= '0;
    end else if (data_valid || (state == S_IDLE)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle; a byte in that
  // cycle takes priority.
  assign tmo_fire = (state != S_IDLE) && !data_valid &&
                    (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_fire = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      ALU_EN  <= 1'b0;
      cmd_err <= 1'b0;
      busy    <= 1'b0;
      Address <= '0;
      WrData  <= '0;
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_FUN <= '0;
    end else begin
      state   <= state_nxt;
      WrEn    <= wr_en_nxt;
      RdEn    <= rd_en_nxt;
      ALU_EN  <= alu_en_nxt;
      cmd_err <= cmd_err_nxt;
      busy    <= busy_nxt;
      Address <= address_nxt;
      WrData  <= wr_data_nxt;
      ALU_A   <= alu_a_nxt;
      ALU_B   <= alu_b_nxt;
      ALU_FUN <= alu_fun_nxt;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_nxt   = state;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    alu_en_nxt  = 1'b0;
    cmd_err_nxt = 1'b0;
    address_nxt = Address;
    wr_data_nxt = WrData;
    alu_a_nxt   = ALU_A;
    alu_b_nxt   = ALU_B;
    alu_fun_nxt = ALU_FUN;

    if (data_valid) begin
      unique case (state)
        S_IDLE: begin
          // Only the first byte of a frame is decoded as a command.
          if (P_DATA == CMD_WR) begin
            state_nxt = S_WR_ADDR;
          end else if (P_DATA == CMD_RD) begin
            state_nxt = S_RD_ADDR;
          end else if (P_DATA == CMD_ALU) begin
            state_nxt = S_ALU_A;
          end else if (P_DATA == CMD_NOP) begin
            state_nxt = S_ALU_FUN;
          end else begin
            cmd_err_nxt = 1'b1;
          end
        end
        S_WR_ADDR: begin
          address_nxt = P_DATA[ADDR_WIDTH-1:0];
          state_nxt   = S_WR_DATA;
        end
        S_WR_DATA: begin
          wr_data_nxt = P_DATA;
          wr_en_nxt   = 1'b1;
          state_nxt   = S_IDLE;
        end
        S_RD_ADDR: begin
          address_nxt = P_DATA[ADDR_WIDTH-1:0];
          rd_en_nxt   = 1'b1;
          state_nxt   = S_IDLE;
        end
        S_ALU_A: begin
          alu_a_nxt = P_DATA;
          state_nxt = S_ALU_B;
        end
        S_ALU_B: begin
          alu_b_nxt = P_DATA;
          state_nxt = S_ALU_FUN;
        end
        S_ALU_FUN: begin
          alu_fun_nxt = P_DATA[FUN_WIDTH-1:0];
          alu_en_nxt  = 1'b1;
          state_nxt   = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end else if (tmo_fire) begin
      // Abandon the partial frame; latched fields are kept.
      state_nxt   = S_IDLE;
      cmd_err_nxt = 1'b1;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Self-checking bench for rx_cmd_decoder: a table of byte vectors with the
// expected registered outputs one cycle later, checked through a scoreboard
// queue, plus hand sequences for mid-frame reset and (optionally) timeout.

module tb_rx_cmd_decoder;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       WrEn, RdEn, ALU_EN, cmd_err, busy;
  logic [3:0] Address;
  logic [7:0] WrData, ALU_A, ALU_B;
  logic [3:0] ALU_FUN;

  rx_cmd_decoder #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .FUN_WIDTH     (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .Address   (Address),
    .WrData    (WrData),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALU_FUN   (ALU_FUN),
    .ALU_EN    (ALU_EN),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic       alu;
    logic       err;
    logic       bsy;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] fun;
  } out_t;

  typedef struct {
    logic       dv;
    logic [7:0] data;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_idx = 0;

  function automatic vec_t mk(input logic dv, input logic [7:0] data,
                              input logic wr, input logic rd, input logic alu,
                              input logic err, input logic bsy,
                              input logic [3:0] addr, input logic [7:0] wd,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [3:0] fun);
    vec_t v;
    v.dv   = dv;
    v.data = data;
    v.exp  = '{wr: wr, rd: rd, alu: alu, err: err, bsy: bsy,
               addr: addr, wd: wd, a: a, b: b, fun: fun};
    return v;
  endfunction

  function automatic out_t sample();
    return {WrEn, RdEn, ALU_EN, cmd_err, busy, Address, WrData, ALU_A, ALU_B, ALU_FUN};
  endfunction

  task automatic chk(input string name, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got wr=%b rd=%b alu=%b err=%b busy=%b addr=%h wd=%h a=%h b=%h fun=%h, exp wr=%b rd=%b alu=%b err=%b busy=%b addr=%h wd=%h a=%h b=%h fun=%h",
               name, act.wr, act.rd, act.alu, act.err, act.bsy, act.addr, act.wd, act.a, act.b, act.fun,
               exp.wr, exp.rd, exp.alu, exp.err, exp.bsy, exp.addr, exp.wd, exp.a, exp.b, exp.fun);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b exp %b", name, act, exp);
    end
  endtask

  // Drive one cycle of input, push its expectation, compare one edge later.
  task automatic apply(input vec_t v, input string tag);
    out_t exp;
    @(negedge CLK);
    data_valid = v.dv;
    P_DATA     = v.data;
    sb.push_back(v.exp);
    @(posedge CLK);
    #1;
    data_valid = 1'b0;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = sb.pop_front();
      chk($sformatf("%s[%0d]", tag, vec_idx), sample(), exp);
    end
    vec_idx++;
  endtask

  initial begin
    RST        = 1'b0;
    data_valid = 1'b0;
    P_DATA     = 8'h00;

    // Stimulus table: byte in, outputs expected one cycle later.
    //                dv data  wr rd alu err bsy addr wd     a      b      fun
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 1, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0));
    tbl.push_back(mk(1, 8'h05, 0, 0, 0, 0, 1, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0));
    tbl.push_back(mk(1, 8'h3C, 1, 0, 0, 0, 0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0));
    tbl.push_back(mk(0, 8'hBB, 0, 0, 0, 0, 0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0));
    tbl.push_back(mk(1, 8'hBB, 0, 0, 0, 0, 1, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0));
    tbl.push_back(mk(1, 8'h1F, 0, 1, 0, 0, 0, 4'hF, 8'h3C, 8'h00, 8'h00, 4'h0));
    tbl.push_back(mk(1, 8'hCC, 0, 0, 0, 0, 1, 4'hF, 8'h3C, 8'h00, 8'h00, 4'h0));
    tbl.push_back(mk(1, 8'h12, 0, 0, 0, 0, 1, 4'hF, 8'h3C, 8'h12, 8'h00, 4'h0));
    tbl.push_back(mk(1, 8'h34, 0, 0, 0, 0, 1, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h0));
    tbl.push_back(mk(1, 8'h02, 0, 0, 1, 0, 0, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h2));
    tbl.push_back(mk(1, 8'hDD, 0, 0, 0, 0, 1, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h2));
    tbl.push_back(mk(1, 8'h03, 0, 0, 1, 0, 0, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 1, 0, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(0, 8'hAA, 0, 0, 0, 0, 0, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 1, 4'hF, 8'h3C, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 1, 4'hA, 8'h3C, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(1, 8'hAA, 1, 0, 0, 0, 0, 4'hA, 8'hAA, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 1, 4'hA, 8'hAA, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(0, 8'hCC, 0, 0, 0, 0, 1, 4'hA, 8'hAA, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(1, 8'h07, 0, 0, 0, 0, 1, 4'h7, 8'hAA, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(0, 8'hDD, 0, 0, 0, 0, 1, 4'h7, 8'hAA, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(1, 8'h11, 1, 0, 0, 0, 0, 4'h7, 8'h11, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(1, 8'hDD, 0, 0, 0, 0, 1, 4'h7, 8'h11, 8'h12, 8'h34, 4'h3));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 1, 0, 0, 4'h7, 8'h11, 8'h12, 8'h34, 4'hF));
    tbl.push_back(mk(1, 8'hBB, 0, 0, 0, 0, 1, 4'h7, 8'h11, 8'h12, 8'h34, 4'hF));
    tbl.push_back(mk(1, 8'hAA, 0, 1, 0, 0, 0, 4'hA, 8'h11, 8'h12, 8'h34, 4'hF));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 1, 0, 4'hA, 8'h11, 8'h12, 8'h34, 4'hF));

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", sample(), '0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("after_reset_release", sample(), '0);

    vec_idx = 0;
    foreach (tbl[i]) apply(tbl[i], "tbl");

    // Reset in the middle of a write frame discards it.
    vec_idx = 0;
    apply(mk(1, 8'hAA, 0, 0, 0, 0, 1, 4'hA, 8'h11, 8'h12, 8'h34, 4'hF), "rst_seq");
    apply(mk(1, 8'h03, 0, 0, 0, 0, 1, 4'h3, 8'h11, 8'h12, 8'h34, 4'hF), "rst_seq");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("async_reset_outputs", sample(), '0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    apply(mk(1, 8'h7E, 0, 0, 0, 1, 0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0), "rst_seq");
    apply(mk(0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0), "rst_seq");

`ifdef FRAME_TIMEOUT_EN
    begin
      int   err_at;
      int   err_cnt;
      logic wr_seen;
      vec_idx = 0;
      apply(mk(1, 8'hAA, 0, 0, 0, 0, 1, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0), "tmo_seq");
      apply(mk(1, 8'h03, 0, 0, 0, 0, 1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0), "tmo_seq");
      err_at  = -1;
      err_cnt = 0;
      wr_seen = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(posedge CLK);
        #1;
        if (c == 15) chk_bit("tmo_busy_before", busy, 1'b1);
        if (WrEn) wr_seen = 1'b1;
        if (cmd_err) begin
          err_cnt++;
          if (err_at < 0) err_at = c;
        end
      end
      chk_bit("tmo_err_seen", (err_at == 16), 1'b1);
      chk_bit("tmo_err_single", (err_cnt == 1), 1'b1);
      chk_bit("tmo_no_wren", wr_seen, 1'b0);
      chk_bit("tmo_busy_after", busy, 1'b0);
      apply(mk(1, 8'hAA, 0, 0, 0, 0, 1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0), "tmo_seq");
      apply(mk(1, 8'h03, 0, 0, 0, 0, 1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0), "tmo_seq");
      apply(mk(1, 8'h99, 1, 0, 0, 0, 0, 4'h3, 8'h99, 8'h00, 8'h00, 4'h0), "tmo_seq");
    end
`endif

    chk_bit("scoreboard_drained", (sb.size() == 0), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
